// File: rtl/redux_mem_pkg.sv
// Shared definitions for the data-memory side: bus widths, command opcodes and
// the copy engine state encoding.
package redux_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 8;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Command interface (core <-> engine) and data-memory port (engine <-> memoria_dados).
interface mem_copy_engine_if
    import redux_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill_val;
    logic              ready;
    logic              done;
    logic [ADDR_W-1:0] count;

    modport master (output start, op, src, dst, len, fill_val,
                    input  ready, done, count);
    modport slave  (input  start, op, src, dst, len, fill_val,
                    output ready, done, count);
endinterface

interface mem_bus_if
    import redux_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
);
    logic [ADDR_W-1:0] position;
    logic [DATA_W-1:0] data_in;
    logic              mw;
    logic [DATA_W-1:0] data_out;

    modport master (output position, data_in, mw, input data_out);
    modport slave  (input  position, data_in, mw, output data_out);
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill initiator for the 8-bit data memory. All memory-side
// outputs are registered and set up on the edge that enters the owning state.
module mem_copy_engine
    import redux_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned READ_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_copy_engine_if.slave   cmd,
    mem_bus_if.master          mem
);

    state_e            state_q;
    logic              op_q;
    logic [ADDR_W-1:0] src_q, dst_q, rem_q, count_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W-1:0] pos_q;
    logic [DATA_W-1:0] din_q;
    logic              mw_q, done_q, ready_q;

    logic [ADDR_W-1:0] src_d, dst_d, rem_d, count_d;

    always_comb begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        count_d = count_q + 1'b1;
    end

    // The read byte goes straight into the write-data register, which doubles as buf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            fill_q  <= '0;
            pos_q   <= '0;
            din_q   <= '0;
            mw_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            pos_q  <= '0;
            din_q  <= '0;
            mw_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd.start) begin
                        op_q    <= cmd.op;
                        src_q   <= cmd.src;
                        dst_q   <= cmd.dst;
                        rem_q   <= cmd.len;
                        fill_q  <= cmd.fill_val;
                        count_q <= '0;
                        ready_q <= 1'b0;
                        if (cmd.len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (cmd.op == OP_FILL) begin
                            state_q <= WR;
                            pos_q   <= cmd.dst;
                            din_q   <= cmd.fill_val;
                            mw_q    <= 1'b1;
                        end else begin
                            state_q <= RD;
                            pos_q   <= cmd.src;
                        end
                    end
                end
                RD: begin
                    if (READ_LAT == 0) begin
                        state_q <= WR;
                        pos_q   <= dst_q;
                        din_q   <= mem.data_out;
                        mw_q    <= 1'b1;
                    end else begin
                        state_q <= RD_WAIT;
                        pos_q   <= src_q;
                    end
                end
                RD_WAIT: begin
                    state_q <= WR;
                    pos_q   <= dst_q;
                    din_q   <= mem.data_out;
                    mw_q    <= 1'b1;
                end
                WR: begin
                    src_q   <= src_d;
                    dst_q   <= dst_d;
                    rem_q   <= rem_d;
                    count_q <= count_d;
                    if (rem_q == ADDR_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (op_q == OP_FILL) begin
                        pos_q <= dst_d;
                        din_q <= fill_q;
                        mw_q  <= 1'b1;
                    end else begin
                        state_q <= RD;
                        pos_q   <= src_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd.ready    = ready_q;
    assign cmd.done     = done_q;
    assign cmd.count    = count_q;
    assign mem.position = pos_q;
    assign mem.data_in  = din_q;
    assign mem.mw       = mw_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine against a behavioural combinational-read
// memoria_dados model.
module tb_mem_copy_engine;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) cif ();
    mem_bus_if         #(.ADDR_W(8), .DATA_W(8)) mbus ();

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .READ_LAT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cif),
        .mem   (mbus)
    );

    logic [7:0] ram [256];
    logic       ld_we;
    logic [7:0] ld_addr, ld_data;
    int         wr_total = 0;

    assign mbus.data_out = ram[mbus.position];

    always @(posedge clk) begin
        if (mbus.mw) ram[mbus.position] <= mbus.data_in;
        else if (ld_we) ram[ld_addr] <= ld_data;
    end

    always @(posedge clk) if (mbus.mw) wr_total <= wr_total + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Issues one command and follows it until done, checking each write address.
    task automatic run_cmd(input logic o, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input bit poke_busy,
                           output int cyc, output logic [31:0] pat, output int nwr);
        logic [7:0] exp_pos;
        @(negedge clk);
        cif.op = o; cif.src = s; cif.dst = d; cif.len = l; cif.fill_val = f;
        cif.start = 1'b1;
        @(posedge clk);
        #1 cif.start = 1'b0;
        cyc = 1; pat = '0; nwr = 0;
        forever begin
            @(negedge clk);
            if (poke_busy && cyc == 2) begin
                cif.start = 1'b1; cif.op = 1'b1; cif.dst = 8'h80; cif.len = 8'd2;
            end else begin
                cif.start = 1'b0;
            end
            pat = {pat[30:0], mbus.mw};
            if (mbus.mw) begin
                exp_pos = d + 8'(nwr);
                check_eq("wr_pos", 32'(mbus.position), 32'(exp_pos));
                nwr++;
            end else begin
                check_eq("din_idle", 32'(mbus.data_in), 32'h0);
            end
            if (cif.done) break;
            if (cyc >= 600) begin
                check_eq("done_timeout", 32'(cif.done), 32'h1);
                break;
            end
            @(posedge clk);
            cyc++;
        end
        cif.start = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", 32'(cif.done), 32'h0);
        check_eq("ready_after", 32'(cif.ready), 32'h1);
    endtask

    int          cyc, nwr, base, seen;
    logic [31:0] pat;

    initial begin
        rst_n = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        cif.start = 1'b0; cif.op = 1'b0; cif.src = '0; cif.dst = '0;
        cif.len = '0; cif.fill_val = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_ready", 32'(cif.ready), 32'h1);
        check_eq("rst_done",  32'(cif.done),  32'h0);
        check_eq("rst_count", 32'(cif.count), 32'h0);
        check_eq("rst_pos",   32'(mbus.position), 32'h0);
        check_eq("rst_din",   32'(mbus.data_in),  32'h0);
        check_eq("rst_mw",    32'(mbus.mw),       32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) poke(8'(i), init_val(8'(i)));
        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
        poke(8'h23, 8'h04); poke(8'h24, 8'h05); poke(8'h25, 8'h06);
        poke(8'h50, 8'h7E);

        // Fill 4 bytes at 0x10
        run_cmd(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 1'b0, cyc, pat, nwr);
        check_eq("fill_cycles", 32'(cyc), 32'd5);
        check_eq("fill_mw_pat", pat, 32'b11110);
        check_eq("fill_nwr",    32'(nwr), 32'd4);
        check_eq("fill_count",  32'(cif.count), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("fill_ram", 32'(ram[8'h10 + i]), 32'hA5);
        check_eq("fill_ram_next", 32'(ram[8'h14]), 32'(init_val(8'h14)));

        // Copy 3 bytes 0x20 -> 0x40
        run_cmd(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 1'b0, cyc, pat, nwr);
        check_eq("copy_cycles", 32'(cyc), 32'd7);
        check_eq("copy_mw_pat", pat, 32'b0101010);
        check_eq("copy_count",  32'(cif.count), 32'd3);
        check_eq("copy_ram0", 32'(ram[8'h40]), 32'h01);
        check_eq("copy_ram1", 32'(ram[8'h41]), 32'h02);
        check_eq("copy_ram2", 32'(ram[8'h42]), 32'h03);

        // Fill wrapping past 0xFF
        run_cmd(1'b1, 8'h00, 8'hFE, 8'd3, 8'h09, 1'b0, cyc, pat, nwr);
        check_eq("wrap_nwr",   32'(nwr), 32'd3);
        check_eq("wrap_count", 32'(cif.count), 32'd3);
        check_eq("wrap_fe", 32'(ram[8'hFE]), 32'h09);
        check_eq("wrap_ff", 32'(ram[8'hFF]), 32'h09);
        check_eq("wrap_00", 32'(ram[8'h00]), 32'h09);
        check_eq("wrap_01", 32'(ram[8'h01]), 32'(init_val(8'h01)));

        // Zero-length command
        run_cmd(1'b1, 8'h00, 8'h30, 8'd0, 8'hEE, 1'b0, cyc, pat, nwr);
        check_eq("len0_cycles", 32'(cyc), 32'd1);
        check_eq("len0_nwr",    32'(nwr), 32'd0);
        check_eq("len0_count",  32'(cif.count), 32'd0);
        check_eq("len0_ram",    32'(ram[8'h30]), 32'(init_val(8'h30)));

        // Start while busy must be ignored
        base = wr_total;
        run_cmd(1'b1, 8'h00, 8'h60, 8'd5, 8'h33, 1'b1, cyc, pat, nwr);
        check_eq("busy_nwr",    32'(nwr), 32'd5);
        check_eq("busy_cycles", 32'(cyc), 32'd6);
        check_eq("busy_ram64",  32'(ram[8'h64]), 32'h33);
        repeat (5) @(negedge clk);
        check_eq("busy_writes", 32'(wr_total - base), 32'd5);
        check_eq("busy_ram80",  32'(ram[8'h80]), 32'(init_val(8'h80)));
        check_eq("busy_ready",  32'(cif.ready), 32'h1);

        // Overlapping forward copy propagates the first byte
        run_cmd(1'b0, 8'h50, 8'h51, 8'd3, 8'h00, 1'b0, cyc, pat, nwr);
        check_eq("ovl_51", 32'(ram[8'h51]), 32'h7E);
        check_eq("ovl_52", 32'(ram[8'h52]), 32'h7E);
        check_eq("ovl_53", 32'(ram[8'h53]), 32'h7E);
        check_eq("ovl_54", 32'(ram[8'h54]), 32'(init_val(8'h54)));

        // Reset during the third write cycle of a 6-byte copy
        base = wr_total;
        seen = 0;
        @(negedge clk);
        cif.op = 1'b0; cif.src = 8'h20; cif.dst = 8'h90; cif.len = 8'd6; cif.start = 1'b1;
        @(posedge clk);
        #1 cif.start = 1'b0;
        for (int i = 0; i < 100 && seen < 3; i++) begin
            @(negedge clk);
            if (mbus.mw) seen++;
        end
        check_eq("rst_seen3", 32'(seen), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_mw",    32'(mbus.mw), 32'h0);
        check_eq("rst_mid_ready", 32'(cif.ready), 32'h1);
        check_eq("rst_mid_count", 32'(cif.count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rst_writes", 32'(wr_total - base), 32'd2);
        check_eq("rst_ram90",  32'(ram[8'h90]), 32'h01);
        check_eq("rst_ram91",  32'(ram[8'h91]), 32'h02);
        check_eq("rst_ram92",  32'(ram[8'h92]), 32'(init_val(8'h92)));
        check_eq("rst_ready",  32'(cif.ready), 32'h1);
        check_eq("rst_count2", 32'(cif.count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Memory-side initiator for the 8-bit data memory (`memoria_dados`). It drives `position`, `data_in` and `mw`, and samples `data_out`.
- Executes block copy and block fill commands over the 256-byte data space, so the core does not have to loop load/store instructions.
- Sits between the core's command interface and the data memory port; the core arbitrates memory ownership while `ready`=0.

Parameters:
- ADDR_W, 8, address width of the data memory; pointer wrap is modulo 2^ADDR_W.
- DATA_W, 8, data width of the data memory.
- READ_LAT, 0, memory read latency in cycles: 0 = combinational `data_out`, 1 = registered `data_out`. Only 0 and 1 are legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; accepted only when ready=1.
- op  input  1  0 = copy src->dst, 1 = fill dst with fill_val.
- src  input  ADDR_W  copy source base address.
- dst  input  ADDR_W  destination base address.
- len  input  ADDR_W  byte count; 0 means no transfer.
- fill_val  input  DATA_W  fill pattern byte.
- ready  output  1  engine idle and able to accept a command.
- done  output  1  one-cycle pulse when a command completes.
- count  output  ADDR_W  bytes written by the current or last command.
- mem_position  output  ADDR_W  memory address, to memoria_dados.position.
- mem_data_in  output  DATA_W  write data, to memoria_dados.data_in.
- mem_mw  output  1  write enable, to memoria_dados.mw.
- mem_data_out  input  DATA_W  read data, from memoria_dados.data_out.

Behaviour:
- Clocking: one clock domain, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: ready=1, done=0, count=0, mem_position=0, mem_data_in=0, mem_mw=0. All state returns to IDLE.
- Reset mid-operation: mem_mw drops to 0 asynchronously and no further write occurs. Any partially transferred block is left as-is.
- States:
  - IDLE: ready=1, mem_mw=0, mem_position=0. On start=1, latch op, src, dst, len and fill_val; clear count.
    - If len=0, go to DONE.
    - Otherwise go to RD when op=0, or WR when op=1.
  - RD (copy only): mem_position=src_ptr, mem_mw=0.
    - READ_LAT=0: capture mem_data_out into buf at the end of this cycle, then go to WR.
    - READ_LAT=1: go to RD_WAIT.
  - RD_WAIT: hold mem_position=src_ptr. Capture mem_data_out into buf, then go to WR.
  - WR: mem_position=dst_ptr, mem_data_in=buf (copy) or fill_val (fill), mem_mw=1 for exactly one cycle.
    - Then src_ptr+1, dst_ptr+1, count+1, remaining-1.
    - If remaining reaches 0, go to DONE.
    - Otherwise go to RD (copy) or stay in WR (fill).
  - DONE: done=1 for one cycle, ready=0, mem_mw=0. Then go to IDLE.
- Throughput:
  - Copy: 2 cycles/byte (READ_LAT=0) or 3 cycles/byte (READ_LAT=1).
  - Fill: 1 cycle/byte.
- Latency:
  - From start acceptance to the done pulse: N*cpb + 1 cycles, where cpb is the cycles/byte above.
  - len=0: done is asserted on the cycle after acceptance.
- Pointers wrap modulo 256: 0xFF+1 = 0x00. The len value cannot exceed 255, so no byte is written twice through wrap.
- Overlap: copy is strictly forward, byte by byte. If dst lies in (src, src+len), already-copied bytes propagate. This is the defined semantics; the engine is not a memmove.
- Commands: start while ready=0 is ignored and has no effect. Input operands are don't-care outside the acceptance cycle.
- count holds its final value after done until the next accepted start.
- mem_data_in is 0 whenever mem_mw=0.
- mem_mw is never asserted in IDLE, RD, RD_WAIT or DONE.

Decomposition:
- Shared package `redux_mem_pkg`:
  - state encoding enum: IDLE, RD, RD_WAIT, WR, DONE.
  - OP_COPY=1'b0, OP_FILL=1'b1.
  - memory ADDR_W/DATA_W defaults shared with `memoria_dados`.
- Single module, with no sub-module required. A behavioural `memoria_dados` instance is used only in the bench.

Test Plan:
- Fill, op=1, dst=0x10, len=4, fill_val=0xA5: mem_mw high exactly 4 consecutive cycles at positions 0x10..0x13; RAM[0x10..0x13]=0xA5, RAM[0x14] unchanged; done pulses 1 cycle later; count=4.
- Copy, READ_LAT=0, RAM[0x20..0x22]={0x01,0x02,0x03}, src=0x20, dst=0x40, len=3: RAM[0x40..0x42]={0x01,0x02,0x03}; done occurs 7 cycles after acceptance; mem_mw never high during read cycles.
- Wrap, op=1, dst=0xFE, len=3, fill_val=0x09: bytes written at 0xFE, 0xFF, 0x00; RAM[0x01] unchanged; count=3.
- len=0 and start-while-busy:
  - start with len=0: done pulses on the next cycle, mem_mw stays 0, count=0.
  - a second start during a fill of len=5: ignored; exactly 5 writes occur.
- Overlap copy, RAM[0x50]=0x7E, src=0x50, dst=0x51, len=3: RAM[0x51..0x53]=0x7E (forward propagation).
- Reset mid-copy: deassert rst_n after the 2nd write of a len=6 copy; mem_mw falls immediately; ready=1 and count=0 after release; no further writes.
